// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types and constants, also used by the register-status
// table and the reservation stations.
package reorder_buffer_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int ROB_TAG_W   = 6;
    localparam int ROB_IDX_W   = 4;
    localparam int ROB_REG_W   = 5;
    localparam int ROB_DATA_W  = 32;

    localparam logic [ROB_TAG_W-1:0] ROB_INVALID_TAG = 6'b010000;

    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic [ROB_REG_W-1:0]  dest;
        logic [ROB_DATA_W-1:0] value;
    } rob_entry_t;

    // Only tags of the form {2'b00, idx} name an entry.
    function automatic logic rob_tag_valid(input logic [ROB_TAG_W-1:0] tag);
        return tag[ROB_TAG_W-1:ROB_IDX_W] == '0;
    endfunction

    function automatic logic [ROB_TAG_W-1:0] rob_make_tag(input logic [ROB_IDX_W-1:0] idx);
        return {2'b00, idx};
    endfunction

endpackage

// File: rtl/reorder_buffer_ptr.sv
// rob_ptr: 4-bit wrapping pointer with increment and synchronous clear;
// clear wins over increment.
module rob_ptr
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ROB_IDX_W-1:0] ptr
);

    logic [ROB_IDX_W-1:0] ptr_q;
    logic [ROB_IDX_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + ROB_IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; next state is
    // computed with blocking assignments in always_comb only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer with CDB capture and operand query.
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to the query port.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_dest,
    output logic                 alloc_ready,
    output logic [ROB_TAG_W-1:0] alloc_tag,
    input  logic                 cdb_valid,
    input  logic [ROB_TAG_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0]    cdb_value,
    input  logic [ROB_TAG_W-1:0] query_tag,
    output logic                 query_ready,
    output logic [DATA_W-1:0]    query_value,
    output logic                 commit_valid,
    output logic [4:0]           commit_reg,
    output logic [ROB_TAG_W-1:0] commit_tag,
    output logic [DATA_W-1:0]    commit_value,
    input  logic                 flush,
    output logic [4:0]           count
);

    rob_entry_t entries_q [ENTRIES];
    rob_entry_t entries_d [ENTRIES];

    logic [4:0]           count_q, count_d;
    logic                 commit_valid_q, commit_valid_d;
    logic [4:0]           commit_reg_q, commit_reg_d;
    logic [ROB_TAG_W-1:0] commit_tag_q, commit_tag_d;
    logic [DATA_W-1:0]    commit_value_q, commit_value_d;

    logic [ROB_IDX_W-1:0] head, tail;
    logic [ROB_IDX_W-1:0] cdb_idx, query_idx;
    logic                 alloc_fire, commit_fire, cdb_hit, query_hit;

    assign cdb_idx     = cdb_tag[ROB_IDX_W-1:0];
    assign query_idx   = query_tag[ROB_IDX_W-1:0];
    assign alloc_ready = (count_q != 5'(ENTRIES));
    assign alloc_tag   = alloc_ready ? rob_make_tag(tail) : ROB_INVALID_TAG;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = (count_q != '0) && entries_q[head].ready;
    assign cdb_hit     = cdb_valid && rob_tag_valid(cdb_tag) && entries_q[cdb_idx].busy;
    assign query_hit   = rob_tag_valid(query_tag) && entries_q[query_idx].busy;

    rob_ptr u_head (
        .clk (clk),
        .rst (rst),
        .inc (commit_fire && !flush),
        .clr (flush),
        .ptr (head)
    );

    rob_ptr u_tail (
        .clk (clk),
        .rst (rst),
        .inc (alloc_fire && !flush),
        .clr (flush),
        .ptr (tail)
    );

    // Flush overrides allocation, CDB capture and commit on the same edge.
    always_comb begin
        entries_d      = entries_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_reg_d   = commit_reg_q;
        commit_tag_d   = commit_tag_q;
        commit_value_d = commit_value_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_d[i].busy  = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                entries_d[tail] = '{busy: 1'b1, ready: 1'b0, dest: alloc_dest, value: '0};
            end
            if (cdb_hit) begin
                entries_d[cdb_idx].ready = 1'b1;
                entries_d[cdb_idx].value = ROB_DATA_W'(cdb_value);
            end
            if (commit_fire) begin
                commit_valid_d  = 1'b1;
                commit_reg_d    = entries_q[head].dest;
                commit_tag_d    = rob_make_tag(head);
                commit_value_d  = DATA_W'(entries_q[head].value);
                entries_d[head] = '0;
            end
            count_d = count_q + {4'd0, alloc_fire} - {4'd0, commit_fire};
        end
    end

    // NOTE: the entry array is reset explicitly because a mid-run reset must
    // drop every in-flight entry; it is small enough to live in flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_reg_q   <= '0;
            commit_tag_q   <= '0;
            commit_value_q <= '0;
        end else begin
            entries_q      <= entries_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_q   <= commit_reg_d;
            commit_tag_q   <= commit_tag_d;
            commit_value_q <= commit_value_d;
        end
    end

    always_comb begin
        query_ready = 1'b0;
        query_value = '0;
        if (query_hit && entries_q[query_idx].ready) begin
            query_ready = 1'b1;
            query_value = DATA_W'(entries_q[query_idx].value);
        end
`ifdef ROB_CDB_BYPASS_EN
        if (query_hit && cdb_valid && rob_tag_valid(cdb_tag) && (cdb_idx == query_idx)) begin
            query_ready = 1'b1;
            query_value = cdb_value;
        end
`endif
    end

    assign commit_valid = commit_valid_q;
    assign commit_reg   = commit_reg_q;
    assign commit_tag   = commit_tag_q;
    assign commit_value = commit_value_q;
    assign count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a commit scoreboard fed at allocation
// time plus per-scenario inline checks.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_dest = '0;
    logic        alloc_ready;
    logic [5:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic [5:0]  query_tag = 6'h10;
    logic        query_ready;
    logic [31:0] query_value;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [5:0]  commit_tag;
    logic [31:0] commit_value;
    logic        flush = 1'b0;
    logic [4:0]  count;

    typedef struct {
        logic [5:0] tag;
        logic [4:0] dest;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] model_val [16];
    logic [3:0]  exp_tail = '0;
    int          passed = 0;
    int          total = 0;
    int          commit_cnt = 0;
    int          base;
    logic        byp_exp;

    reorder_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_dest   (alloc_dest),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .query_tag    (query_tag),
        .query_ready  (query_ready),
        .query_value  (query_value),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
        .flush        (flush),
        .count        (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Every retire is matched against the oldest outstanding allocation.
    always @(negedge clk) begin
        if (!rst && commit_valid) begin
            commit_cnt++;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_commit got tag=%h reg=%0d, expected no commit", commit_tag, commit_reg);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (commit_tag !== e.tag || commit_reg !== e.dest || commit_value !== model_val[e.tag[3:0]])
                    $display("FAIL commit_order got tag=%h reg=%0d val=%h, expected tag=%h reg=%0d val=%h",
                             commit_tag, commit_reg, commit_value, e.tag, e.dest, model_val[e.tag[3:0]]);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one cycle of stimulus; acc tells whether the allocation should be accepted.
    task automatic cycle(input logic av, input logic [4:0] d, input logic cv,
                         input logic [5:0] ct, input logic [31:0] cval,
                         input logic fl, input logic acc);
        alloc_valid = av;
        alloc_dest  = d;
        cdb_valid   = cv;
        cdb_tag     = ct;
        cdb_value   = cval;
        flush       = fl;
        if (fl) begin
            sb.delete();
            exp_tail = '0;
        end else begin
            if (cv && ct[5:4] == 2'b00) model_val[ct[3:0]] = cval;
            if (av && acc) begin
                sb.push_back('{tag: {2'b00, exp_tail}, dest: d});
                exp_tail++;
            end
        end
        tick();
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        alloc_valid = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
        query_tag = 6'h10;
        sb.delete();
        exp_tail = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b expected 1", alloc_ready); else passed++;
        total++; if (alloc_tag !== 6'd0) $display("FAIL reset_alloc_tag got %h expected 00", alloc_tag); else passed++;
        total++; if (count !== 5'd0) $display("FAIL reset_count got %0d expected 0", count); else passed++;
        total++; if (commit_valid !== 1'b0 || commit_reg !== 5'd0 || commit_tag !== 6'd0 || commit_value !== 32'd0)
            $display("FAIL reset_commit got v=%b r=%0d t=%h val=%h expected all 0", commit_valid, commit_reg, commit_tag, commit_value);
        else passed++;
        total++; if (query_ready !== 1'b0 || query_value !== 32'd0) $display("FAIL reset_query got %b/%h expected 0/0", query_ready, query_value); else passed++;
    endtask

    task automatic test_fill_and_full_commit();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            total++; if (alloc_tag !== 6'(i)) $display("FAIL fill_tag got %h expected %h", alloc_tag, 6'(i)); else passed++;
            cycle(1'b1, 5'(i + 1), 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        end
        total++; if (alloc_ready !== 1'b0) $display("FAIL full_ready got %b expected 0", alloc_ready); else passed++;
        total++; if (alloc_tag !== 6'h10) $display("FAIL full_tag got %h expected 10", alloc_tag); else passed++;
        total++; if (count !== 5'd16) $display("FAIL full_count got %0d expected 16", count); else passed++;
        cycle(1'b1, 5'd7, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
        total++; if (count !== 5'd16) $display("FAIL full_ignore got %0d expected 16", count); else passed++;
        // Complete the head, then collide an allocation with its commit.
        cycle(1'b0, 5'd0, 1'b1, 6'd0, 32'hA0, 1'b0, 1'b0);
        cycle(1'b1, 5'd21, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
        total++; if (count !== 5'd15) $display("FAIL full_commit_count got %0d expected 15", count); else passed++;
        total++; if (commit_valid !== 1'b1) $display("FAIL full_commit_pulse got %b expected 1", commit_valid); else passed++;
        total++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd0) $display("FAIL freed_tag got %b/%h expected 1/00", alloc_ready, alloc_tag); else passed++;
        cycle(1'b1, 5'd22, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        total++; if (count !== 5'd16) $display("FAIL refill_count got %0d expected 16", count); else passed++;
    endtask

    task automatic test_in_order_commit();
        apply_reset();
        base = commit_cnt;
        cycle(1'b1, 5'd3, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd4, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd5, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 1'b1, 6'd2, 32'h22, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 1'b1, 6'd0, 32'hA, 1'b0, 1'b0);
        total++; if (commit_valid !== 1'b0) $display("FAIL cdb_commit_latency got %b expected 0", commit_valid); else passed++;
        tick();
        total++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0 || commit_value !== 32'hA)
            $display("FAIL head_commit got %b/%h/%h expected 1/00/0000000a", commit_valid, commit_tag, commit_value);
        else passed++;
        repeat (3) tick();
        total++; if (commit_cnt - base !== 1 || count !== 5'd2) $display("FAIL blocked_by_tag1 got commits=%0d count=%0d expected 1/2", commit_cnt - base, count); else passed++;
        query_tag = 6'd2;
        #1;
        total++; if (query_ready !== 1'b1 || query_value !== 32'h22) $display("FAIL held_query got %b/%h expected 1/00000022", query_ready, query_value); else passed++;
        query_tag = 6'd1;
        #1;
        total++; if (query_ready !== 1'b0) $display("FAIL pending_query got %b expected 0", query_ready); else passed++;
        query_tag = 6'h10;
        cycle(1'b0, 5'd0, 1'b1, 6'd1, 32'h11, 1'b0, 1'b0);
        repeat (4) tick();
        total++; if (commit_cnt - base !== 3 || count !== 5'd0 || sb.size() != 0)
            $display("FAIL drain got commits=%0d count=%0d left=%0d expected 3/0/0", commit_cnt - base, count, sb.size());
        else passed++;
    endtask

    task automatic test_bypass_and_ignore();
        apply_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'(i + 8), 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        query_tag = 6'd5;
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        cdb_value = 32'h55;
        model_val[5] = 32'h55;
`ifdef ROB_CDB_BYPASS_EN
        byp_exp = 1'b1;
`else
        byp_exp = 1'b0;
`endif
        #1;
        total++; if (query_ready !== byp_exp) $display("FAIL bypass_same_cycle got %b expected %b", query_ready, byp_exp); else passed++;
        tick();
        cdb_valid = 1'b0;
        #1;
        total++; if (query_ready !== 1'b1 || query_value !== 32'h55) $display("FAIL query_next_cycle got %b/%h expected 1/00000055", query_ready, query_value); else passed++;
        cycle(1'b0, 5'd0, 1'b1, 6'h13, 32'h99, 1'b0, 1'b0);
        query_tag = 6'd3;
        #1;
        total++; if (query_ready !== 1'b0 || query_value !== 32'd0) $display("FAIL invalid_cdb_tag got %b/%h expected 0/0", query_ready, query_value); else passed++;
        cycle(1'b0, 5'd0, 1'b1, 6'd9, 32'h77, 1'b0, 1'b0);
        query_tag = 6'd9;
        #1;
        total++; if (query_ready !== 1'b0 || query_value !== 32'd0 || count !== 5'd6)
            $display("FAIL nonbusy_cdb got %b/%h count=%0d expected 0/0/6", query_ready, query_value, count);
        else passed++;
        query_tag = 6'h10;
        #1;
        total++; if (query_ready !== 1'b0 || query_value !== 32'd0) $display("FAIL invalid_query got %b/%h expected 0/0", query_ready, query_value); else passed++;
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 5'(i), 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 1'b1, 6'd1, 32'h1111, 1'b0, 1'b0);
        cycle(1'b1, 5'd9, 1'b1, 6'd0, 32'hF0, 1'b1, 1'b0);
        total++; if (count !== 5'd0 || commit_valid !== 1'b0) $display("FAIL flush_state got count=%0d cv=%b expected 0/0", count, commit_valid); else passed++;
        total++; if (alloc_tag !== 6'd0) $display("FAIL flush_alloc_tag got %h expected 00", alloc_tag); else passed++;
        query_tag = 6'd1;
        #1;
        total++; if (query_ready !== 1'b0) $display("FAIL flush_query got %b expected 0", query_ready); else passed++;
        query_tag = 6'h10;
        repeat (3) tick();
        total++; if (count !== 5'd0) $display("FAIL flush_settle got %0d expected 0", count); else passed++;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'(i + 1), 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 1'b1, 6'd0, 32'hBEEF, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        exp_tail = '0;
        #1;
        total++; if (count !== 5'd0) $display("FAIL async_reset_count got %0d expected 0", count); else passed++;
        tick();
        total++; if (commit_valid !== 1'b0) $display("FAIL reset_no_commit got %b expected 0", commit_valid); else passed++;
        rst = 1'b0;
        repeat (3) tick();
        total++; if (count !== 5'd0 || alloc_tag !== 6'd0) $display("FAIL post_reset got count=%0d tag=%h expected 0/00", count, alloc_tag); else passed++;
    endtask

    task automatic test_back_to_back_wrap();
        apply_reset();
        base = commit_cnt;
        for (int i = 0; i < 20; i++) begin
            total++; if (count !== 5'((i < 2) ? i : 2) || count > 5'd16)
                $display("FAIL wrap_count got %0d expected %0d", count, (i < 2) ? i : 2);
            else passed++;
            total++; if (alloc_tag !== 6'(i % 16)) $display("FAIL wrap_tag got %h expected %h", alloc_tag, 6'(i % 16)); else passed++;
            cycle(1'b1, 5'(i), i > 0, 6'((i + 15) % 16), 32'h100 + 32'(i) - 32'd1, 1'b0, 1'b1);
        end
        cycle(1'b0, 5'd0, 1'b1, 6'd3, 32'h113, 1'b0, 1'b0);
        repeat (4) tick();
        total++; if (commit_cnt - base !== 20 || count !== 5'd0 || sb.size() != 0)
            $display("FAIL wrap_drain got commits=%0d count=%0d left=%0d expected 20/0/0", commit_cnt - base, count, sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_and_full_commit();
        test_in_order_commit();
        test_bypass_and_ignore();
        test_flush();
        test_reset_mid_run();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of ROB entries; it is fixed at 16 so that tags fit in 4 bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the result value width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have the following ports, each listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- alloc_valid  in  1  dispatch request.
- alloc_dest  in  5  architectural destination register.
- alloc_ready  out  1  an entry is free.
- alloc_tag  out  6  tag granted, for the register-status write data.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  6  tag of the broadcast result.
- cdb_value  in  DATA_W  broadcast result value.
- query_tag  in  6  operand tag from the register-status table.
- query_ready  out  1  the queried entry holds a result.
- query_value  out  DATA_W  result value of the queried entry.
- commit_valid  out  1  one-cycle retire pulse.
- commit_reg  out  5  register being retired.
- commit_tag  out  6  tag being retired.
- commit_value  out  DATA_W  value being retired.
- flush  in  1  discard all entries.
- count  out  5  number of occupied entries, 0..16.

Function
REQ-005 Tags SHALL be {2'b00, idx[3:0]}; the invalid tag SHALL be 6'b010000, and any tag with bit4 set SHALL be treated as "no entry".
REQ-006 Storage SHALL be a circular buffer addressed by 4-bit head and tail pointers; each entry holds busy, ready, dest[4:0] and value.
REQ-007 alloc_ready SHALL equal (count != 16), combinationally.
REQ-008 alloc_tag SHALL equal {2'b00, tail} when alloc_ready is 1, else 6'b010000, combinationally.
REQ-009 On a clock edge with alloc_valid && alloc_ready, the entry at tail SHALL get busy=1, ready=0 and dest=alloc_dest, and tail SHALL increment modulo 16.
REQ-010 alloc_valid while full SHALL be ignored, with no state change.
REQ-011 On a clock edge with cdb_valid, a valid tag and the addressed entry busy, that entry SHALL get ready=1 and value=cdb_value.
REQ-012 A CDB write to a non-busy entry, or with an invalid tag, SHALL be ignored.
REQ-013 Commit, evaluated per edge: if count>0 and entry[head] is ready, then the next cycle SHALL have commit_valid=1 with that entry's dest, tag and value; the entry SHALL be cleared and head SHALL increment modulo 16. Otherwise commit_valid SHALL be 0. Commit is at most one per cycle and strictly in order.
REQ-014 A CDB write landing at head SHALL commit no earlier than the edge after the write (minimum CDB-to-commit_valid latency is 2 edges).
REQ-015 count SHALL update each edge by +1 for an accepted allocation and -1 for a commit; with both on the same edge, count SHALL be unchanged.
REQ-016 Allocation at full on the same edge as a commit SHALL be refused, because alloc_ready was 0 during that cycle.
REQ-017 query_ready and query_value SHALL be combinational from the entry at query_tag; an invalid tag or a non-busy entry SHALL give query_ready=0 and query_value=0.
REQ-018 Synchronous flush SHALL clear every busy and ready bit, set head=tail=0, count=0 and commit_valid=0 on the next edge.
REQ-019 Flush SHALL take priority over same-edge allocation, CDB write and commit.
REQ-020 commit_reg=0 SHALL be retired normally; filtering of register 0 is the register file's job.

Reset
REQ-021 rst SHALL asynchronously clear all entries, set head=tail=0, count=0 and commit_valid=0, and zero commit_reg, commit_tag and commit_value.
REQ-022 After reset, alloc_ready SHALL be 1 and alloc_tag SHALL be 6'd0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight entries without emitting any commit pulse.

Configuration
REQ-024 Macro ROB_CDB_BYPASS_EN: when defined, a query matching cdb_tag while cdb_valid=1 and the entry is busy SHALL return query_ready=1 and query_value=cdb_value in the same cycle.
REQ-025 When ROB_CDB_BYPASS_EN is undefined, the query SHALL see the result only from the cycle after the CDB edge.

Structure
REQ-026 A shared package SHALL hold ROB_TAG_W=6, ROB_IDX_W=4, ROB_INVALID_TAG=6'b010000 and the entry struct type, also used by the register-status table and the reservation stations.
REQ-027 The block SHALL have one sub-module, rob_ptr, a 4-bit wrapping pointer with increment and clear, instantiated for head and tail.

Verification
REQ-028 Reset, then 16 allocations with dest=1..16: required response is alloc_tag 0..15 in order, then alloc_ready=0, alloc_tag=6'b010000, count=16.
REQ-029 With tags 0..2 allocated, CDB to tag 2 and then tag 0 (value 0xA): required response is commit of tag 0 (value 0xA) only, with tag 1 blocking and tag 2 held until tag 1 completes.
REQ-030 With the buffer full, commit and alloc_valid on the same edge: required response is allocation refused and count 15; the next-cycle allocation gets the freed tag.
REQ-031 CDB to tag 5 with query_tag=5 in the same cycle: required response is query_ready=1 with ROB_CDB_BYPASS_EN defined, and 0 until the next cycle without it.
REQ-032 flush with 7 entries busy plus simultaneous alloc_valid and cdb_valid: required response is count=0, no commit pulse, and a subsequent alloc_tag of 0.
REQ-033 Wrap-around: 20 allocate/complete/commit cycles: required response is tags 0..15 followed by 0..3, with commits in order and count never exceeding 16.
